// File: rtl/lcu_stim_check.sv
// lcu_stim_check: drives an up/down comparator pair with LFSR-generated
// count/threshold controls, tracks a reference model of its registers and
// checks the 20 comparison flags coming back on every RUN cycle.
module lcu_stim_check #(
  parameter int unsigned RUN_LEN = 4096,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] flags_in,
  output logic        count_sw,
  output logic        thresh_sw,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_err_cycle,
  output logic [19:0] first_err_flags
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(RUN_LEN - 1);

  // Ten flags for one counter/threshold pair: zero, max, then unsigned and
  // signed forms of >, <, >=, <=.
  function automatic logic [9:0] cmp_flags(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [9:0]         f;
    sa   = $signed(a);
    sb   = $signed(b);
    f[0] = (a == 32'd0);
    f[1] = (a == 32'hFFFF_FFFF);
    f[2] = (a > b);
    f[3] = (sa > sb);
    f[4] = (a < b);
    f[5] = (sa < sb);
    f[6] = (a >= b);
    f[7] = (sa >= sb);
    f[8] = (a <= b);
    f[9] = (sa <= sb);
    return f;
  endfunction

  // Error counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] idx_q, idx_d;
  logic        count_sw_q  = 1'b0;
  logic        thresh_sw_q = 1'b1;
  logic        count_sw_d, thresh_sw_d;
  logic [15:0] err_count_q, err_count_d;
  logic [15:0] first_err_cycle_q, first_err_cycle_d;
  logic [19:0] first_err_flags_q, first_err_flags_d;

  // Model registers are never reset: they mirror the external DUT, which
  // only sees count_sw/thresh_sw, so they start from configuration values.
  logic [31:0] cnt_q    = 32'd0;
  logic [31:0] cnt_dn_q = 32'd0;
  logic [31:0] thr_q    = 32'hFFFF_FFE1;
  logic [31:0] thr_dn_q = 32'h0000_001F;
  logic [31:0] cnt_d, cnt_dn_d, thr_d, thr_dn_d;

  logic [19:0] expected;
  logic [19:0] mismatch_vec;

  assign expected     = {cmp_flags(cnt_dn_q, thr_dn_q), cmp_flags(cnt_q, thr_q)};
  assign mismatch_vec = flags_in ^ expected;

  // Next state of the reference model, driven by the registered controls.
  always_comb begin
    cnt_d    = cnt_q;
    cnt_dn_d = cnt_dn_q;
    if (count_sw_q) begin
      cnt_d    = cnt_q + 32'd1;
      cnt_dn_d = cnt_dn_q - 32'd1;
    end
    if (thresh_sw_q) begin
      thr_d    = cnt_q - 32'd31;
      thr_dn_d = cnt_dn_q + 32'd31;
    end else begin
      thr_d    = thr_q + 32'd1;
      thr_dn_d = thr_dn_q - 32'd1;
    end
  end

  // Reference model registers, updated every edge including reset cycles.
  always_ff @(posedge clk) begin
    cnt_q    <= cnt_d;
    cnt_dn_q <= cnt_dn_d;
    thr_q    <= thr_d;
    thr_dn_q <= thr_dn_d;
  end

  // FSM next state, stimulus generation and error accounting.
  always_comb begin
    state_d           = state_q;
    lfsr_d            = lfsr_q;
    idx_d             = idx_q;
    err_count_d       = err_count_q;
    first_err_cycle_d = first_err_cycle_q;
    first_err_flags_d = first_err_flags_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d           = RUN;
          lfsr_d            = SEED;
          idx_d             = 16'd0;
          err_count_d       = 16'd0;
          first_err_cycle_d = 16'd0;
          first_err_flags_d = 20'd0;
        end
      end
      RUN: begin
        lfsr_d = lfsr_step(lfsr_q);
        idx_d  = idx_q + 16'd1;
        if (mismatch_vec != 20'd0) begin
          err_count_d = sat_inc16(err_count_q);
          // A saturated count never returns to zero, so zero marks "no error yet".
          if (err_count_q == 16'd0) begin
            first_err_cycle_d = idx_q;
            first_err_flags_d = mismatch_vec;
          end
        end
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outside RUN the counters freeze and the thresholds are pinned.
    count_sw_d  = (state_d == RUN) ? lfsr_d[0] : 1'b0;
    thresh_sw_d = (state_d == RUN) ? (lfsr_d[1] & lfsr_d[2]) : 1'b1;
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      lfsr_q            <= SEED;
      idx_q             <= 16'd0;
      count_sw_q        <= 1'b0;
      thresh_sw_q       <= 1'b1;
      err_count_q       <= 16'd0;
      first_err_cycle_q <= 16'd0;
      first_err_flags_q <= 20'd0;
    end else begin
      state_q           <= state_d;
      lfsr_q            <= lfsr_d;
      idx_q             <= idx_d;
      count_sw_q        <= count_sw_d;
      thresh_sw_q       <= thresh_sw_d;
      err_count_q       <= err_count_d;
      first_err_cycle_q <= first_err_cycle_d;
      first_err_flags_q <= first_err_flags_d;
    end
  end

  assign count_sw        = count_sw_q;
  assign thresh_sw       = thresh_sw_q;
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = done && (err_count_q == 16'd0);
  assign err_count       = err_count_q;
  assign first_err_cycle = first_err_cycle_q;
  assign first_err_flags = first_err_flags_q;

endmodule
